// File: rtl/demux_1_4_32_pkg.sv
// Shared definitions for the demux_1_4_32 router: default width, sink-select codes,
// buffer-occupancy state encodings and the head-select one-hot decode.
package demux_1_4_32_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SEL_W      = 2;
  localparam int N_SINK     = 4;

  localparam logic [SEL_W-1:0] SEL_SINK0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_SINK1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_SINK2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_SINK3 = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic logic [N_SINK-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_SINK-1:0] oh;
    oh = '0;
    case (sel)
      SEL_SINK0: oh = 4'b0001;
      SEL_SINK1: oh = 4'b0010;
      SEL_SINK2: oh = 4'b0100;
      SEL_SINK3: oh = 4'b1000;
      default:   oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_4_32_fifo2_34.sv
// Two-entry in-order buffer holding {sel,data}; head/tail registers with an
// EMPTY/ONE/TWO occupancy FSM and a registered write-ready.
module fifo2_34
  import demux_1_4_32_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_data_i,
  input  logic         wr_valid_i,
  output logic         wr_ready_o,
  output logic [W-1:0] rd_data_o,
  output logic         rd_valid_o,
  input  logic         rd_ready_i
);

  state_e         state_q, state_d;
  logic [W-1:0]   head_q, head_d;
  logic [W-1:0]   tail_q, tail_d;
  logic           rdy_q;
  logic           wr_fire;
  logic           rd_fire;

  assign wr_fire = wr_valid_i & rdy_q;
  assign rd_fire = rd_ready_i & (state_q != ST_EMPTY);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (wr_fire) begin
          head_d  = wr_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (wr_fire && rd_fire) begin
          head_d = wr_data_i;
        end else if (wr_fire) begin
          tail_d  = wr_data_i;
          state_d = ST_TWO;
        end else if (rd_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (rd_fire) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Ready is registered so it stays low for the whole reset and rises on the first edge after release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      rdy_q   <= (state_d != ST_TWO);
    end
  end

  assign wr_ready_o = rdy_q;
  assign rd_data_o  = head_q;
  assign rd_valid_o = (state_q != ST_EMPTY);

endmodule

// File: rtl/demux_1_4_32.sv
// Registered 1-to-4 word router with a 2-deep in-order buffer (head-of-line blocking).
// Optional per-sink transfer counters on cnt_flat when DEMUX_COUNT_EN is defined.
module demux_1_4_32
  import demux_1_4_32_pkg::*;
#(
`ifdef DEMUX_COUNT_EN
  parameter int CNT_W  = 16,
`endif
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [N_SINK-1:0] out_valid,
  input  logic [N_SINK-1:0] out_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [N_SINK*CNT_W-1:0] cnt_flat
`endif
);

  logic [DATA_W+SEL_W-1:0] head;
  logic                    head_vld;
  logic                    drain;

  fifo2_34 #(
    .W (DATA_W + SEL_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data_i  ({in_sel, in_data}),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .rd_data_o  (head),
    .rd_valid_o (head_vld),
    .rd_ready_i (drain)
  );

  // Only the addressed sink's ready can retire the head word.
  assign out_data  = head[DATA_W-1:0];
  assign out_valid = head_vld ? sel_onehot(head[DATA_W+SEL_W-1:DATA_W]) : '0;
  assign drain     = |(out_valid & out_ready);

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt_q [N_SINK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SINK; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_SINK; k++) begin
        if (out_valid[k] && out_ready[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_SINK; g++) begin : g_cnt
    assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_demux_1_4_32.sv
// Directed bench for demux_1_4_32: reset, single word, streaming, back-pressure,
// head-of-line blocking, reset mid-transfer and (with DEMUX_COUNT_EN) counters.
module tb_demux_1_4_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt_flat;
`endif

  int n_checks = 0;
  int n_errors = 0;

  demux_1_4_32 #(
`ifdef DEMUX_COUNT_EN
    .CNT_W  (4),
`endif
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt_flat  (cnt_flat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 4'b1111;
    drive(1'b1, 2'd1, 32'hAAAA_5555);

    // Reset held two cycles with in_valid high
    step();
    step();
    check_eq("rst_out_valid", 64'(out_valid), 64'h0);
    check_eq("rst_out_data",  64'(out_data),  64'h0);
    check_eq("rst_in_ready",  64'(in_ready),  64'h0);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 32'h0);
    step();
    check_eq("rel_in_ready",  64'(in_ready),  64'h1);
    check_eq("rel_out_valid", 64'(out_valid), 64'h0);

    // Single word to sink 2
    drive(1'b1, 2'd2, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 2'd0, 32'h0);
    check_eq("single_valid", 64'(out_valid), 64'h4);
    check_eq("single_data",  64'(out_data),  64'hDEAD_BEEF);
    step();
    check_eq("single_empty", 64'(out_valid), 64'h0);
    check_eq("single_ready", 64'(in_ready),  64'h1);

    // Streaming: one word per cycle, in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 32'h1000 + 32'(i));
      step();
      check_eq($sformatf("stream_rdy%0d", i),   64'(in_ready),  64'h1);
      check_eq($sformatf("stream_vld%0d", i),   64'(out_valid), 64'(4'b0001 << (i % 4)));
      check_eq($sformatf("stream_dat%0d", i),   64'(out_data),  64'h1000 + 64'(i));
    end
    drive(1'b0, 2'd0, 32'h0);
    step();
    check_eq("stream_empty", 64'(out_valid), 64'h0);

    // Back-pressure: three words to sink 1 while all sinks stalled
    out_ready = 4'b0000;
    drive(1'b1, 2'd1, 32'h2000);
    step();
    check_eq("bp_rdy_after1", 64'(in_ready), 64'h1);
    drive(1'b1, 2'd1, 32'h2001);
    step();
    check_eq("bp_rdy_after2", 64'(in_ready), 64'h0);
    drive(1'b1, 2'd1, 32'h2002);
    step();
    check_eq("bp_rdy_held",   64'(in_ready),  64'h0);
    check_eq("bp_head_vld",   64'(out_valid), 64'h2);
    check_eq("bp_head_dat",   64'(out_data),  64'h2000);
    out_ready = 4'b0010;
    step();
    check_eq("bp_drain1_dat", 64'(out_data),  64'h2001);
    check_eq("bp_drain1_rdy", 64'(in_ready),  64'h1);
    step();
    drive(1'b0, 2'd0, 32'h0);
    check_eq("bp_drain2_dat", 64'(out_data),  64'h2002);
    check_eq("bp_drain2_vld", 64'(out_valid), 64'h2);
    step();
    check_eq("bp_empty",      64'(out_valid), 64'h0);

    // Head-of-line: sink 3 stalled blocks a word for sink 0
    out_ready = 4'b0111;
    drive(1'b1, 2'd3, 32'h3003);
    step();
    drive(1'b1, 2'd0, 32'h3000);
    step();
    drive(1'b0, 2'd0, 32'h0);
    check_eq("hol_vld0", 64'(out_valid), 64'h8);
    check_eq("hol_dat0", 64'(out_data),  64'h3003);
    step();
    step();
    check_eq("hol_vld2", 64'(out_valid), 64'h8);
    check_eq("hol_dat2", 64'(out_data),  64'h3003);
    check_eq("hol_rdy2", 64'(in_ready),  64'h0);
    out_ready = 4'b1000;
    step();
    check_eq("hol_next_vld", 64'(out_valid), 64'h1);
    check_eq("hol_next_dat", 64'(out_data),  64'h3000);
    step();
    check_eq("hol_stall0", 64'(out_valid), 64'h1);
    out_ready = 4'b0001;
    step();
    check_eq("hol_empty",  64'(out_valid), 64'h0);

    // Reset mid-transfer discards buffered words
    out_ready = 4'b0000;
    drive(1'b1, 2'd2, 32'h4444);
    step();
    drive(1'b0, 2'd0, 32'h0);
    check_eq("mid_loaded", 64'(out_valid), 64'h4);
    out_ready = 4'b1111;
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_vld", 64'(out_valid), 64'h0);
    check_eq("mid_rst_dat", 64'(out_data),  64'h0);
    check_eq("mid_rst_rdy", 64'(in_ready),  64'h0);
    rst_n = 1'b1;
    step();
    check_eq("mid_rel_rdy", 64'(in_ready),  64'h1);
    check_eq("mid_rel_vld", 64'(out_valid), 64'h0);

`ifdef DEMUX_COUNT_EN
    // 17 transfers to sink 2 wrap a 4-bit counter to 1
    check_eq("cnt_after_rst", 64'(cnt_flat), 64'h0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 2'd2, 32'h5000 + 32'(i));
      step();
    end
    drive(1'b0, 2'd0, 32'h0);
    step();
    check_eq("cnt_sink2", 64'(cnt_flat[11:8]), 64'h1);
    check_eq("cnt_flat",  64'(cnt_flat),       64'h0100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
